// File: rtl/full_adder_4.sv
// Registered WIDTH-bit ripple-carry adder with carry, signed-overflow and zero flags.
// One-cycle latency; a result is presented with a single-cycle out_valid pulse.
module full_adder_4 #(
  parameter int unsigned WIDTH       = 4,
  parameter              CARRY_CHAIN = "RIPPLE"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign c[0] = cin;

  if (CARRY_CHAIN == "RIPPLE") begin : g_ripple
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end else begin : g_unsupported
    $error("full_adder_4: CARRY_CHAIN must be \"RIPPLE\"");
  end

  // Result registers hold their value on idle cycles; only out_valid tracks in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s         <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s        <= sum;
        carry    <= c[WIDTH];
        overflow <= c[WIDTH] ^ c[WIDTH-1];
      end
    end
  end

  // Derived from the registered sum, so it reads 1 during reset and ignores carry.
  assign zero = ~|s;

endmodule

// File: tb/tb_full_adder_4.sv
// Scoreboard bench for full_adder_4: driver pushes reference results, a negedge
// monitor pops and compares them against whatever the DUT presents.
module tb_full_adder_4;

  typedef struct packed {
    logic [3:0] s;
    logic       carry;
    logic       ovf;
    logic       zero;
  } exp_t;

  localparam exp_t ResetExp = '{s: 4'h0, carry: 1'b0, ovf: 1'b0, zero: 1'b1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       cin = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] s;
  logic       carry;
  logic       overflow;
  logic       zero;
  logic       out_valid;

  int   checks = 0;
  int   errors = 0;
  int   run = 0;
  exp_t last = ResetExp;
  exp_t sb[$];

  full_adder_4 #(.WIDTH(4), .CARRY_CHAIN("RIPPLE")) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .in_valid (in_valid),
    .s        (s),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic.
  function automatic exp_t model(input logic [3:0] av, input logic [3:0] bv, input logic cv);
    int   u;
    int   sa;
    int   sbv;
    int   sr;
    exp_t e;
    u   = int'(av) + int'(bv) + int'(cv);
    sa  = (av > 4'd7) ? int'(av) - 16 : int'(av);
    sbv = (bv > 4'd7) ? int'(bv) - 16 : int'(bv);
    sr  = sa + sbv + int'(cv);
    e.s     = 4'(u % 16);
    e.carry = (u >= 16);
    e.ovf   = (sr > 7) || (sr < -8);
    e.zero  = ((u % 16) == 0);
    return e;
  endfunction

  // Expectation is pushed on the edge that samples the inputs.
  always @(posedge clk) begin
    if (!rst && in_valid) sb.push_back(model(a, b, cin));
  end

  // A sample in flight when reset hits must never be reported.
  always @(posedge rst) begin
    sb.delete();
    last = ResetExp;
    run  = 0;
  end

  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    if (!rst) begin
      got = '{s: s, carry: carry, ovf: overflow, zero: zero};
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      if (out_valid) begin
        run++;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("result{s,carry,ovf,zero}", 32'(got), 32'(e));
          last = e;
        end
      end else begin
        run = 0;
        if (sb.size() != 0) void'(sb.pop_front());
        chk("hold{s,carry,ovf,zero}", 32'(got), 32'(last));
      end
    end
  end

  task automatic step(input logic iv, input logic [3:0] av, input logic [3:0] bv,
                      input logic cv);
    in_valid = iv;
    a        = av;
    b        = bv;
    cin      = cv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] v;
    #2;
    chk("reset_s", 32'(s), 32'h0);
    chk("reset_carry", 32'(carry), 32'h0);
    chk("reset_overflow", 32'(overflow), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_zero", 32'(zero), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b0);

    // Six directed vectors back-to-back.
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0001, 4'b0001, 1'b1);
    step(1'b1, 4'b0110, 4'b1100, 1'b1);
    step(1'b1, 4'b0110, 4'b0001, 1'b1);
    step(1'b1, 4'b1110, 4'b0001, 1'b1);
    step(1'b1, 4'b1111, 4'b1111, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("back_to_back_run", 32'(run), 32'd6);
    chk("last_s_all_ones", 32'(s), 32'hf);
    @(posedge clk);
    #1;
    step(1'b0, 4'h3, 4'h5, 1'b1);

    // Exhaustive sweep with random idle gaps.
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      if ($urandom_range(0, 3) == 0) step(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
      step(1'b1, v[8:5], v[4:1], v[0]);
    end

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom), 1'($urandom));
    end

    // Reset between edges while a result is presented and another vector pending.
    step(1'b1, 4'b0101, 4'b0110, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_s", 32'(s), 32'h0);
    chk("async_rst_carry", 32'(carry), 32'h0);
    chk("async_rst_overflow", 32'(overflow), 32'h0);
    chk("async_rst_out_valid", 32'(out_valid), 32'h0);
    chk("async_rst_zero", 32'(zero), 32'h1);
    in_valid = 1'b1;
    a        = 4'b1001;
    b        = 4'b1001;
    cin      = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_held_out_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    step(1'b0, 4'h0, 4'h0, 1'b0);
    step(1'b1, 4'b0111, 4'b0001, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_adder_4.md
FULL_ADDER_4 -- requirements
Module: full_adder_4

Interface
- REQ-001: Parameter WIDTH, default 4, operand/sum width; only 4 is required to be supported and verified.
- REQ-002: Parameter CARRY_CHAIN, default "RIPPLE", selects the structural ripple chain of 1-bit full-adder cells, which is the only legal value.
- REQ-003: Port clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-004: Port rst, input, 1, reset; asynchronous and active-high.
- REQ-005: Port a, input, WIDTH, operand A (unsigned, also readable as two's complement).
- REQ-006: Port b, input, WIDTH, operand B.
- REQ-007: Port cin, input, 1, carry-in to bit 0.
- REQ-008: Port in_valid, input, 1, a/b/cin are sampled when high on a clk rising edge.
- REQ-009: Port s, output, WIDTH, registered sum bits.
- REQ-010: Port carry, output, 1, registered carry-out of the MSB cell.
- REQ-011: Port overflow, output, 1, registered signed overflow, i.e. carry into MSB XOR carry out of MSB.
- REQ-012: Port zero, output, 1, registered flag, high when s is all zeros.
- REQ-013: Port out_valid, output, 1, high for one cycle when s/carry/overflow/zero hold a new result.

Function
- REQ-014: The adder datapath shall be WIDTH 1-bit full-adder cells; cell i computes sum_i = a_i XOR b_i XOR c_i and c_(i+1) = a_i·b_i + c_i·(a_i XOR b_i), with c_0 = cin.
- REQ-015: {carry, s} shall equal a + b + cin, computed modulo 2^(WIDTH+1) with no saturation.
- REQ-016: Latency shall be exactly one clock: a/b/cin sampled at edge N with in_valid=1 shall appear on the outputs after edge N, with out_valid=1 in cycle N+1.
- REQ-017: When in_valid=0 at an edge, s/carry/overflow/zero shall hold their previous values and out_valid shall be 0 for the next cycle.
- REQ-018: Back-to-back in_valid=1 on consecutive edges shall produce one result per cycle, with no stall and no backpressure.
- REQ-019: overflow shall be 1 only when a and b have the same MSB and the MSB of the sum differs from it, after cin is included.
- REQ-020: zero shall be computed from the registered sum only, independent of carry.
- REQ-021: Wrap-around: the all-ones operands with cin=1 shall give s=all ones and carry=1; the unsigned maximum +1 shall wrap s to 0 and set carry=1.
- REQ-022: Inputs shall have no other side effects; the block shall contain no state other than the output registers and out_valid.

Reset
- REQ-023: While rst=1, regardless of clk, s, carry, overflow and out_valid shall be 0 immediately (asynchronous), and zero shall be 1.
- REQ-024: An in_valid sample coinciding with, or in flight at, rst assertion shall be discarded and produce no out_valid.
- REQ-025: After rst deasserts, the first rising edge with in_valid=1 shall be processed normally.

Verification
- REQ-026: a=0000, b=0000, cin=0 -> s=0000, carry=0, zero=1, overflow=0; then a=0001, b=0001, cin=1 -> s=0011, carry=0, zero=0.
- REQ-027: a=0110, b=1100, cin=1 -> s=0011, carry=1, overflow=0; then a=0110, b=0001, cin=1 -> s=1000, carry=0, overflow=1.
- REQ-028: a=1110, b=0001, cin=1 -> s=0000, carry=1, zero=1; then a=1111, b=1111, cin=1 -> s=1111, carry=1, overflow=0.
- REQ-029: Drive these six vectors on consecutive edges with in_valid=1 -> each result appears exactly one cycle later and out_valid stays high for six cycles.
- REQ-030: Assert rst mid-stream between clock edges -> outputs clear at once without waiting for an edge and out_valid=0; the pending vector is never output.
- REQ-031: Run an exhaustive sweep of all 512 (a,b,cin) combinations -> {carry,s}==a+b+cin and overflow/zero match the reference model on every result.
